// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU control path: opcode constants, instruction
// class encoding, control-sequencer state encoding and the register-select
// one-hot expansion helper. Imported by the sequencer, the opcode decoder
// and the ALU.
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned OPCODE_W = 5;
    localparam int unsigned REG_SEL_W = 4;
    localparam int unsigned NUM_REGS = 16;

    // Opcode map (ir[31:27])
    localparam logic [OPCODE_W-1:0] OP_ADD  = 5'd0;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 5'd1;
    localparam logic [OPCODE_W-1:0] OP_AND  = 5'd2;
    localparam logic [OPCODE_W-1:0] OP_OR   = 5'd3;
    localparam logic [OPCODE_W-1:0] OP_SHR  = 5'd4;
    localparam logic [OPCODE_W-1:0] OP_SHL  = 5'd5;
    localparam logic [OPCODE_W-1:0] OP_ROR  = 5'd6;
    localparam logic [OPCODE_W-1:0] OP_ROL  = 5'd7;
    localparam logic [OPCODE_W-1:0] OP_LD   = 5'd8;
    localparam logic [OPCODE_W-1:0] OP_ST   = 5'd9;
    localparam logic [OPCODE_W-1:0] OP_MUL  = 5'd15;
    localparam logic [OPCODE_W-1:0] OP_DIV  = 5'd16;
    localparam logic [OPCODE_W-1:0] OP_HALT = 5'd31;

    // Instruction class, as produced by opcode_decode
    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_MUL,
        CLS_DIV,
        CLS_LD,
        CLS_ST,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_e;

    // Control sequencer states
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_F0,
        ST_F1,
        ST_F2,
        ST_DEC,
        ST_E0,
        ST_E1,
        ST_E2,
        ST_E3,
        ST_HALT
    } seq_state_e;

    // Expand a 4-bit register number into a 16-bit one-hot select.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_SEL_W-1:0] sel);
        logic [NUM_REGS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            oh[i] = (sel == REG_SEL_W'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/opcode_decode.sv
// -----------------------------------------------------------------------------
// opcode_decode
// Purely combinational opcode classifier.
//   opcode   : in  5-bit instruction opcode (ir[31:27])
//   op_class : out instruction class (ALU, MUL, DIV, LD, ST, HALT, ILLEGAL)
//   legal    : out 1 when the opcode is defined
// -----------------------------------------------------------------------------
module opcode_decode
    import cpu_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output op_class_e           op_class,
    output logic                legal
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        legal    = 1'b1;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: op_class = CLS_ALU;
            OP_MUL:                         op_class = CLS_MUL;
            OP_DIV:                         op_class = CLS_DIV;
            OP_LD:                          op_class = CLS_LD;
            OP_ST:                          op_class = CLS_ST;
            OP_HALT:                        op_class = CLS_HALT;
            default: begin
                op_class = CLS_ILLEGAL;
                legal    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Hardwired control unit: fetches an instruction over the memory handshake,
// classifies it and steps the datapath through up to four execute phases.
//   clock      : in  sole clock, rising edge
//   clear      : in  asynchronous active-low reset
//   run        : in  permits a new fetch (sampled in IDLE and at completion)
//   ir[31:0]   : in  instruction register: op[31:27] ra[26:23] rb[22:19] rc[18:15]
//   mem_ack    : in  memory completion strobe
//   alu_done   : in  multi-cycle divide complete
//   pco..loi   : out datapath load / bus-drive strobes
//   r_in/r_out : out one-hot register-file load / drive selects
//   mem_read/mem_write : out memory request, held until mem_ack
//   alu_op     : out ALU operation (0 when unused)
//   halted/illegal : out sticky status flags, cleared only by clear
// -----------------------------------------------------------------------------
module control_sequencer
    import cpu_pkg::*;
(
    input  logic          clock,
    input  logic          clear,
    input  logic          run,
    input  logic [31:0]   ir,
    input  logic          mem_ack,
    input  logic          alu_done,
    output logic          pco,
    output logic          pci,
    output logic          pc_inc,
    output logic          iri,
    output logic          mari,
    output logic          mdri,
    output logic          mdro,
    output logic          ryi,
    output logic          rzi,
    output logic          rzo_lo,
    output logic          rzo_hi,
    output logic          hii,
    output logic          loi,
    output logic [15:0]   r_in,
    output logic [15:0]   r_out,
    output logic          mem_read,
    output logic          mem_write,
    output logic [4:0]    alu_op,
    output logic          halted,
    output logic          illegal
);

    seq_state_e            state_q, state_d;
    op_class_e             cls_q, cls_d;
    logic [OPCODE_W-1:0]   op_q, op_d;
    logic [REG_SEL_W-1:0]  ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
    logic                  halted_q, halted_d;
    logic                  illegal_q, illegal_d;

    op_class_e             dec_class;
    logic                  dec_legal;
    seq_state_e            after_instr;
    logic                  ir_unused;

    // Low instruction bits carry immediates the sequencer does not need.
    assign ir_unused = ^ir[14:0];

    opcode_decode u_opcode_decode (
        .opcode   (ir[31:27]),
        .op_class (dec_class),
        .legal    (dec_legal)
    );

    // run is only looked at when an instruction finishes.
    assign after_instr = run ? ST_F0 : ST_IDLE;

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        op_d      = op_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        rc_d      = rc_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: if (run) state_d = ST_F0;
            ST_F0:   state_d = ST_F1;
            ST_F1:   if (mem_ack) state_d = ST_F2;
            ST_F2:   state_d = ST_DEC;
            ST_DEC: begin
                // Capture the instruction fields so execute does not depend
                // on ir staying stable.
                cls_d = dec_class;
                op_d  = ir[31:27];
                ra_d  = ir[26:23];
                rb_d  = ir[22:19];
                rc_d  = ir[18:15];
                if (dec_class == CLS_HALT || dec_class == CLS_ILLEGAL) begin
                    state_d   = ST_HALT;
                    halted_d  = 1'b1;
                    illegal_d = ~dec_legal;
                end else begin
                    state_d = ST_E0;
                end
            end
            ST_E0:   state_d = ST_E1;
            ST_E1: begin
                case (cls_q)
                    CLS_DIV: if (alu_done) state_d = ST_E2;
                    CLS_LD:  if (mem_ack)  state_d = ST_E2;
                    default: state_d = ST_E2;
                endcase
            end
            ST_E2: begin
                case (cls_q)
                    CLS_MUL, CLS_DIV: state_d = ST_E3;
                    CLS_ST:  if (mem_ack) state_d = after_instr;
                    default: state_d = after_instr;
                endcase
            end
            ST_E3:   state_d = after_instr;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= ST_IDLE;
            cls_q     <= CLS_ALU;
            op_q      <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            rc_q      <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            op_q      <= op_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            rc_q      <= rc_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    // Output decode from the state register. The only input-qualified terms
    // are mdri on a memory-ack cycle and rzi on the divide-complete cycle,
    // which must coincide with the handshake itself. Because every strobe
    // is a function of state_q, clear forces all of them low at once.
    always_comb begin
        pco       = 1'b0;
        pci       = 1'b0;
        pc_inc    = 1'b0;
        iri       = 1'b0;
        mari      = 1'b0;
        mdri      = 1'b0;
        mdro      = 1'b0;
        ryi       = 1'b0;
        rzi       = 1'b0;
        rzo_lo    = 1'b0;
        rzo_hi    = 1'b0;
        hii       = 1'b0;
        loi       = 1'b0;
        r_in      = '0;
        r_out     = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_op    = '0;
        case (state_q)
            ST_F0: begin
                pco    = 1'b1;
                mari   = 1'b1;
                pc_inc = 1'b1;
            end
            ST_F1: begin
                mem_read = 1'b1;
                mdri     = mem_ack;
            end
            ST_F2: begin
                mdro = 1'b1;
                iri  = 1'b1;
            end
            ST_E0: begin
                r_out = reg_onehot(rb_q);
                if (cls_q == CLS_LD || cls_q == CLS_ST) mari = 1'b1;
                else                                     ryi  = 1'b1;
            end
            ST_E1: begin
                case (cls_q)
                    CLS_ALU, CLS_MUL: begin
                        r_out  = reg_onehot(rc_q);
                        rzi    = 1'b1;
                        alu_op = op_q;
                    end
                    CLS_DIV: begin
                        r_out  = reg_onehot(rc_q);
                        alu_op = op_q;
                        rzi    = alu_done;
                    end
                    CLS_LD: begin
                        mem_read = 1'b1;
                        mdri     = mem_ack;
                    end
                    CLS_ST: begin
                        r_out = reg_onehot(ra_q);
                        mdri  = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_E2: begin
                case (cls_q)
                    CLS_ALU: begin
                        rzo_lo = 1'b1;
                        r_in   = reg_onehot(ra_q);
                    end
                    CLS_MUL, CLS_DIV: begin
                        rzo_lo = 1'b1;
                        loi    = 1'b1;
                    end
                    CLS_LD: begin
                        mdro = 1'b1;
                        r_in = reg_onehot(ra_q);
                    end
                    CLS_ST:  mem_write = 1'b1;
                    default: ;
                endcase
            end
            ST_E3: begin
                rzo_hi = 1'b1;
                hii    = 1'b1;
            end
            default: ;
        endcase
    end

    assign halted  = halted_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
// Table of instructions, each expanded into a cycle-by-cycle expected output
// trace that is queued as stimulus is applied and compared as the DUT
// produces it; plus hand-written reset/halt sequences and a random phase with
// bus/one-hot/memory invariants checked every cycle.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

    logic        clock, clear, run, mem_ack, alu_done;
    logic [31:0] ir;
    logic        pco, pci, pc_inc, iri, mari, mdri, mdro, ryi, rzi;
    logic        rzo_lo, rzo_hi, hii, loi;
    logic [15:0] r_in, r_out;
    logic        mem_read, mem_write;
    logic [4:0]  alu_op;
    logic        halted, illegal;

    control_sequencer dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir),
        .mem_ack(mem_ack), .alu_done(alu_done),
        .pco(pco), .pci(pci), .pc_inc(pc_inc), .iri(iri), .mari(mari),
        .mdri(mdri), .mdro(mdro), .ryi(ryi), .rzi(rzi),
        .rzo_lo(rzo_lo), .rzo_hi(rzo_hi), .hii(hii), .loi(loi),
        .r_in(r_in), .r_out(r_out),
        .mem_read(mem_read), .mem_write(mem_write),
        .alu_op(alu_op), .halted(halted), .illegal(illegal)
    );

    typedef struct packed {
        logic        pco, pci, pc_inc, iri, mari, mdri, mdro, ryi, rzi;
        logic        rzo_lo, rzo_hi, hii, loi;
        logic [15:0] r_in, r_out;
        logic        mem_read, mem_write;
        logic [4:0]  alu_op;
        logic        halted, illegal;
    } outs_t;

    outs_t act;
    assign act = {pco, pci, pc_inc, iri, mari, mdri, mdro, ryi, rzi,
                  rzo_lo, rzo_hi, hii, loi, r_in, r_out,
                  mem_read, mem_write, alu_op, halted, illegal};

    localparam int K_ALU = 0, K_MUL = 1, K_DIV = 2, K_LD = 3, K_ST = 4, K_HALT = 5;

    typedef struct {
        logic [31:0] ir;
        int          kind;
        int          fa;      // F1 wait cycles before ack
        int          ea;      // execute memory wait cycles before ack
        int          dd;      // divide cycles before alu_done
        logic        nz;      // drive stray mem_ack/alu_done where they must be ignored
        logic        cont;    // run high through the instruction, chaining into the next
        logic [15:0] e_rout0, e_rout1, e_rin;
        logic [4:0]  e_op;
        logic        e_ill;
    } vec_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    bit    inv_en = 0;
    outs_t sb_q[$];
    string lbl_q[$];
    outs_t m_e;
    string m_l;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mk_ir(input int op, input int ra, input int rb, input int rc);
        return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'h1a5};
    endfunction

    task automatic check(input string name, input outs_t a, input outs_t e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    // One stimulus cycle: drive inputs after the falling edge, queue expectation.
    task automatic cyc(input logic r, input logic a, input logic d, input outs_t e, input string lbl);
        @(negedge clock);
        run      = r;
        mem_ack  = a;
        alu_done = d;
        sb_q.push_back(e);
        lbl_q.push_back(lbl);
    endtask

    // Scoreboard: compare the DUT output for the cycle just driven.
    always @(negedge clock) begin
        #2;
        if (sb_q.size() != 0) begin
            m_e = sb_q.pop_front();
            m_l = lbl_q.pop_front();
            check(m_l, act, m_e);
        end
    end

    // Structural invariants during the random phase.
    always @(negedge clock) begin
        #3;
        if (inv_en) begin
            n_cmp++;
            if ((int'(pco) + int'(mdro) + int'(rzo_lo) + int'(rzo_hi) + $countones(r_out)) > 1) begin
                n_bad++;
                $display("FAIL bus_drivers: got pco=%b mdro=%b rzo_lo=%b rzo_hi=%b r_out=%h expected at most one", pco, mdro, rzo_lo, rzo_hi, r_out);
            end
            n_cmp++;
            if (!$onehot0(r_in) || !$onehot0(r_out)) begin
                n_bad++;
                $display("FAIL reg_onehot: got r_in=%h r_out=%h expected one-hot or zero", r_in, r_out);
            end
            n_cmp++;
            if (mem_read && mem_write) begin
                n_bad++;
                $display("FAIL mem_excl: got mem_read=1 mem_write=1 expected not both");
            end
        end
    end

    task automatic do_clear(input string name);
        @(negedge clock);
        #3 clear = 1'b0;
        #1 check(name, act, '0);
        @(negedge clock);
        clear = 1'b1;
    endtask

    task automatic run_instr(input vec_t v, input int idx, input bit skip_idle);
        outs_t e;
        logic  n, r;
        string p;
        p  = $sformatf("v%0d", idx);
        n  = v.nz;
        r  = v.cont;
        ir = v.ir;
        if (!skip_idle) begin
            e = '0; cyc(1'b1, n, n, e, {p, " idle"});
        end
        e = '0; e.pco = 1; e.mari = 1; e.pc_inc = 1; cyc(r, n, n, e, {p, " F0"});
        for (int i = 0; i < v.fa; i++) begin
            e = '0; e.mem_read = 1; cyc(r, 1'b0, n, e, {p, " F1 wait"});
        end
        e = '0; e.mem_read = 1; e.mdri = 1; cyc(r, 1'b1, n, e, {p, " F1 ack"});
        e = '0; e.mdro = 1; e.iri = 1;      cyc(r, n, n, e, {p, " F2"});
        e = '0;                              cyc(r, n, n, e, {p, " DEC"});
        case (v.kind)
            K_ALU: begin
                e = '0; e.r_out = v.e_rout0; e.ryi = 1; cyc(r, n, n, e, {p, " E0"});
                e = '0; e.r_out = v.e_rout1; e.rzi = 1; e.alu_op = v.e_op; cyc(r, n, n, e, {p, " E1"});
                e = '0; e.rzo_lo = 1; e.r_in = v.e_rin; cyc(v.cont, n, n, e, {p, " E2"});
            end
            K_MUL: begin
                e = '0; e.r_out = v.e_rout0; e.ryi = 1; cyc(r, n, n, e, {p, " E0"});
                e = '0; e.r_out = v.e_rout1; e.rzi = 1; e.alu_op = v.e_op; cyc(r, n, n, e, {p, " E1"});
                e = '0; e.rzo_lo = 1; e.loi = 1; cyc(r, n, n, e, {p, " E2"});
                e = '0; e.rzo_hi = 1; e.hii = 1; cyc(v.cont, n, n, e, {p, " E3"});
            end
            K_DIV: begin
                e = '0; e.r_out = v.e_rout0; e.ryi = 1; cyc(r, n, n, e, {p, " E0"});
                for (int i = 0; i < v.dd; i++) begin
                    e = '0; e.r_out = v.e_rout1; e.alu_op = v.e_op; cyc(r, n, 1'b0, e, {p, " E1 wait"});
                end
                e = '0; e.r_out = v.e_rout1; e.alu_op = v.e_op; e.rzi = 1; cyc(r, n, 1'b1, e, {p, " E1 done"});
                e = '0; e.rzo_lo = 1; e.loi = 1; cyc(r, n, n, e, {p, " E2"});
                e = '0; e.rzo_hi = 1; e.hii = 1; cyc(v.cont, n, n, e, {p, " E3"});
            end
            K_LD: begin
                e = '0; e.r_out = v.e_rout0; e.mari = 1; cyc(r, n, n, e, {p, " E0"});
                for (int i = 0; i < v.ea; i++) begin
                    e = '0; e.mem_read = 1; cyc(r, 1'b0, n, e, {p, " E1 wait"});
                end
                e = '0; e.mem_read = 1; e.mdri = 1; cyc(r, 1'b1, n, e, {p, " E1 ack"});
                e = '0; e.mdro = 1; e.r_in = v.e_rin; cyc(v.cont, n, n, e, {p, " E2"});
            end
            K_ST: begin
                e = '0; e.r_out = v.e_rout0; e.mari = 1; cyc(r, n, n, e, {p, " E0"});
                e = '0; e.r_out = v.e_rout1; e.mdri = 1; cyc(r, n, n, e, {p, " E1"});
                for (int i = 0; i < v.ea; i++) begin
                    e = '0; e.mem_write = 1; cyc(r, 1'b0, n, e, {p, " E2 wait"});
                end
                e = '0; e.mem_write = 1; cyc(v.cont, 1'b1, n, e, {p, " E2 ack"});
            end
            default: begin
                // Halted: run, mem_ack and alu_done activity must change nothing.
                for (int i = 0; i < 4; i++) begin
                    e = '0; e.halted = 1; e.illegal = v.e_ill;
                    cyc(logic'(i % 2 == 0), 1'b1, 1'b1, e, {p, " HALT"});
                end
            end
        endcase
        if (v.kind == K_HALT) begin
            do_clear({p, " clear"});
        end else if (!v.cont) begin
            e = '0; cyc(1'b0, n, n, e, {p, " back idle"});
        end
    endtask

    vec_t        tbl[13];
    logic [4:0]  legal_ops[12];

    initial begin
        outs_t e;
        bit    skip;
        logic [4:0] op;

        //            ir                       kind    fa ea dd nz cont  rout0     rout1     rin      op     ill
        tbl[0]  = '{mk_ir(0, 1, 2, 3),   K_ALU,  1, 0, 0, 0, 1, 16'h0004, 16'h0008, 16'h0002, 5'd0,  0};
        tbl[1]  = '{mk_ir(1, 7, 0, 15),  K_ALU,  0, 0, 0, 1, 0, 16'h0001, 16'h8000, 16'h0080, 5'd1,  0};
        tbl[2]  = '{mk_ir(7, 3, 3, 3),   K_ALU,  0, 0, 0, 0, 0, 16'h0008, 16'h0008, 16'h0008, 5'd7,  0};
        tbl[3]  = '{mk_ir(4, 15, 14, 13),K_ALU,  2, 0, 0, 1, 0, 16'h4000, 16'h2000, 16'h8000, 5'd4,  0};
        tbl[4]  = '{mk_ir(15, 2, 4, 6),  K_MUL,  0, 0, 0, 1, 0, 16'h0010, 16'h0040, 16'h0000, 5'd15, 0};
        tbl[5]  = '{mk_ir(16, 1, 2, 3),  K_DIV,  0, 0, 5, 1, 0, 16'h0004, 16'h0008, 16'h0000, 5'd16, 0};
        tbl[6]  = '{mk_ir(8, 9, 10, 0),  K_LD,   1, 2, 0, 1, 0, 16'h0400, 16'h0000, 16'h0200, 5'd0,  0};
        tbl[7]  = '{mk_ir(9, 4, 5, 0),   K_ST,   0, 3, 0, 1, 0, 16'h0020, 16'h0010, 16'h0000, 5'd0,  0};
        tbl[8]  = '{mk_ir(31, 0, 0, 0),  K_HALT, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 5'd0,  0};
        tbl[9]  = '{mk_ir(20, 1, 2, 3),  K_HALT, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 5'd0,  1};
        tbl[10] = '{mk_ir(10, 0, 0, 0),  K_HALT, 1, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 5'd0,  1};
        tbl[11] = '{mk_ir(16, 0, 1, 2),  K_DIV,  0, 0, 0, 0, 0, 16'h0002, 16'h0004, 16'h0000, 5'd16, 0};
        tbl[12] = '{mk_ir(3, 8, 9, 10),  K_ALU,  3, 0, 0, 1, 0, 16'h0200, 16'h0400, 16'h0100, 5'd3,  0};

        legal_ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd15, 5'd16};

        clear = 1'b0; run = 1'b0; ir = '0; mem_ack = 1'b0; alu_done = 1'b0;
        repeat (2) @(negedge clock);
        #1 check("reset", act, '0);
        @(negedge clock);
        clear = 1'b1;

        skip = 1'b0;
        for (int i = 0; i < 13; i++) begin
            run_instr(tbl[i], i, skip);
            skip = tbl[i].cont;
        end

        // clear during the fetch memory wait
        ir = mk_ir(0, 1, 2, 3);
        e = '0; cyc(1'b1, 1'b0, 1'b0, e, "clr idle");
        e = '0; e.pco = 1; e.mari = 1; e.pc_inc = 1; cyc(1'b0, 1'b0, 1'b0, e, "clr F0");
        e = '0; e.mem_read = 1; cyc(1'b0, 1'b0, 1'b0, e, "clr F1a");
        e = '0; e.mem_read = 1; cyc(1'b0, 1'b0, 1'b0, e, "clr F1b");
        @(negedge clock);
        #4;
        e = '0; e.mem_read = 1;
        check("clr pre", act, e);
        clear = 1'b0;
        #1 check("clr async", act, '0);
        @(negedge clock);
        run = 1'b1; mem_ack = 1'b1;
        @(negedge clock);
        #1 check("clr held", act, '0);
        clear = 1'b1; run = 1'b0; mem_ack = 1'b0;
        e = '0; cyc(1'b0, 1'b0, 1'b0, e, "clr post idle0");
        e = '0; cyc(1'b1, 1'b0, 1'b0, e, "clr post idle1");
        e = '0; e.pco = 1; e.mari = 1; e.pc_inc = 1; cyc(1'b0, 1'b0, 1'b0, e, "clr post F0");
        e = '0; e.mem_read = 1; cyc(1'b0, 1'b0, 1'b0, e, "clr post F1");
        do_clear("clr final");

        // Random phase: invariants only
        inv_en = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clock);
            clear    = (halted || illegal) ? 1'b0 : 1'b1;
            run      = ($urandom_range(0, 7) != 0);
            mem_ack  = ($urandom_range(0, 2) == 0);
            alu_done = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) op = 5'($urandom_range(0, 31));
            else                           op = legal_ops[$urandom_range(0, 11)];
            ir = {op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 15'($urandom)};
        end
        @(negedge clock);
        inv_en = 1'b0;
        clear = 1'b1; run = 1'b0; mem_ack = 1'b0; alu_done = 1'b0;

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port clear, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port run, input, 1, permits a new instruction fetch when high.
REQ-004 SHALL have port ir, input, 32, current instruction register contents: opcode ir[31:27], ra ir[26:23], rb ir[22:19], rc ir[18:15].
REQ-005 SHALL have port mem_ack, input, 1, memory completion strobe for the current read or write.
REQ-006 SHALL have port alu_done, input, 1, multi-cycle divide complete.
REQ-007 SHALL have ports pco, pci, pc_inc, iri, mari, mdri, mdro, ryi, rzi, rzo_lo, rzo_hi, hii, loi, output, 1 each, datapath load and bus-drive strobes.
REQ-008 SHALL have ports r_in and r_out, output, 16 each, one-hot register-file load and drive selects.
REQ-009 SHALL have ports mem_read and mem_write, output, 1 each, memory request held until mem_ack.
REQ-010 SHALL have port alu_op, output, 5, ALU operation select; it is 0 when unused.
REQ-011 SHALL have ports halted and illegal, output, 1 each, sticky status flags.

Function
REQ-012 SHALL implement states IDLE, F0, F1, F2, DEC, E0, E1, E2, E3, HALT; all outputs are registered-state decodes (Moore).
REQ-013 IDLE -> F0 when run=1, else stay.
REQ-014 F0 SHALL assert pco, mari, pc_inc for one cycle.
REQ-015 F1 SHALL assert mem_read each cycle until mem_ack; on the mem_ack cycle it SHALL assert mdri and go to F2; with no ack it stays indefinitely.
REQ-016 F2 SHALL assert mdro and iri; DEC SHALL classify ir[31:27] with no strobes asserted.
REQ-017 ALU class (opcodes 0-7: add, sub, and, or, shr, shl, ror, rol): E0 r_out[rb], ryi; E1 r_out[rc], rzi, alu_op=opcode; E2 rzo_lo, r_in[ra]; then F0 if run=1, else IDLE.
REQ-018 MUL (15) or DIV (16): E0 r_out[rb], ryi; E1 r_out[rc], alu_op=opcode, rzi; for DIV, E1 holds until alu_done with alu_op held and rzi asserted in the completing cycle; E2 rzo_lo, loi; E3 rzo_hi, hii.
REQ-019 LD (8): E0 r_out[rb], mari; E1 mem_read until mem_ack, with mdri on the ack cycle; E2 mdro, r_in[ra].
REQ-020 ST (9): E0 r_out[rb], mari; E1 r_out[ra], mdri; E2 mem_write until mem_ack.
REQ-021 HALT opcode (31) SHALL enter HALT and set halted; any undefined opcode SHALL enter HALT and set halted and illegal; HALT is left only by clear.
REQ-022 Exactly zero or one bus driver SHALL be asserted per cycle (pco, mdro, rzo_lo, rzo_hi, any r_out bit).
REQ-023 r_in and r_out SHALL be one-hot or zero; ra=rb is legal.
REQ-024 mem_ack outside F1, or outside E1 of LD, or outside E2 of ST SHALL be ignored.
REQ-025 alu_done outside DIV E1 SHALL be ignored.
REQ-026 run falling mid-instruction SHALL NOT abort the instruction; it is sampled only at instruction completion and in IDLE.
REQ-027 mem_read and mem_write SHALL never be high simultaneously.

Reset
REQ-028 clear low SHALL force state IDLE, all strobes 0, alu_op 0, halted 0, illegal 0, immediately and independent of clock, including mid-memory-wait.
REQ-029 On the first clock edge after clear deasserts, IDLE behaviour applies.

Structure
REQ-030 Opcode constants, class encodings and state encodings SHALL reside in shared package cpu_pkg, used also by alu.
REQ-031 Opcode classification SHALL be a sub-module opcode_decode (combinational: opcode -> class, legal).
REQ-032 Register-select one-hot expansion SHALL be a function in cpu_pkg.

Verification
REQ-033 Reset, run=1, ir=add r1,r2,r3 (0x00918000), mem_ack in the 2nd F1 cycle -> F0/F1/F1/F2/DEC/E0-E2 sequence; r_out=0x0004 in E0, r_out=0x0008 with alu_op=0 in E1, r_in=0x0002 in E2.
REQ-034 DIV with alu_done after 5 cycles -> E1 lasts 6 cycles, alu_op=16 throughout; loi then hii in successive cycles.
REQ-035 ST r4 -> [r5] with mem_ack delayed 3 cycles -> mem_write high for exactly 4 cycles; no mem_read.
REQ-036 Opcode 20 -> halted=1, illegal=1, all strobes 0; run toggling has no effect until clear.
REQ-037 clear asserted during F1 wait -> mem_read drops asynchronously; IDLE after release.
REQ-038 Random opcodes and acks for 10k cycles -> assertions REQ-022, REQ-023 and REQ-027 never fail.
